// File: rtl/ad9854_pkg.sv
// ad9854_pkg
// Shared widths, writer timing constants, FSM state type and FTW arithmetic
// helpers for the AD9854 sweep controller. No ports.
// Optional feature used by the importing modules: SWEEP_PINGPONG_EN
// (up-then-down sweep passes).
package ad9854_pkg;

  localparam int FTW_W = 32;

  // Downstream register writer timing: length of its write burst and of its
  // setkey debounce shift register.
  localparam int WR_BURST = 17;
  localparam int KEY_SR   = 10;

  typedef enum logic [2:0] {IDLE, PULSE, SETTLE, DWELL, STEP} sweep_state_t;

  // a + b clamped to lim. The sum is taken one bit wider so a carry out of
  // the top bit clamps instead of wrapping to a small frequency.
  function automatic logic [FTW_W-1:0] satAdd(input logic [FTW_W-1:0] a,
                                              input logic [FTW_W-1:0] b,
                                              input logic [FTW_W-1:0] lim);
    logic [FTW_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[FTW_W-1:0];
  endfunction

  // a - b clamped to lim from below. The extra top bit is the borrow, so an
  // underflow past zero also clamps to lim.
  function automatic logic [FTW_W-1:0] satSub(input logic [FTW_W-1:0] a,
                                              input logic [FTW_W-1:0] b,
                                              input logic [FTW_W-1:0] lim);
    logic [FTW_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return (diff[FTW_W] || (diff[FTW_W-1:0] < lim)) ? lim : diff[FTW_W-1:0];
  endfunction

endpackage

// File: rtl/ad9854_sweep_step.sv
// ad9854_sweep_step
// Combinational next-point arithmetic for the sweep controller: the next
// FTW of the pass, the FTW a continuous sweep restarts at, and whether the
// current point is the last of its pass.
// Optional feature: SWEEP_PINGPONG_EN adds a down leg (direction in/out).
// Ports:
//   ftw_i        current FTW on the bus
//   start_i      latched first FTW
//   stop_i       latched last FTW
//   step_i       latched FTW increment
//   single_i     single-set mode, always one point
//   down_i       (pingpong only) current leg is the down leg
//   down_o       (pingpong only) leg of the next point
//   nextFtw_o    FTW of the next point within the pass
//   restartFtw_o first FTW of the next pass when sweeping continuously
//   passEnd_o    current point ends the pass
module ad9854_sweep_step
  import ad9854_pkg::*;
(
  input  logic [FTW_W-1:0] ftw_i,
  input  logic [FTW_W-1:0] start_i,
  input  logic [FTW_W-1:0] stop_i,
  input  logic [FTW_W-1:0] step_i,
  input  logic             single_i,
`ifdef SWEEP_PINGPONG_EN
  input  logic             down_i,
  output logic             down_o,
`endif
  output logic [FTW_W-1:0] nextFtw_o,
  output logic [FTW_W-1:0] restartFtw_o,
  output logic             passEnd_o
);

  // A zero step or an empty/inverted range can only ever produce start.
  logic degenerate;
  assign degenerate = single_i || (step_i == '0) || (start_i >= stop_i);

`ifdef SWEEP_PINGPONG_EN
  // Up leg climbs to stop, turns without repeating stop, then the down leg
  // descends to start where the pass ends.
  always_comb begin
    down_o    = down_i;
    nextFtw_o = satAdd(ftw_i, step_i, stop_i);
    passEnd_o = degenerate;
    if (down_i) begin
      nextFtw_o = satSub(ftw_i, step_i, start_i);
      passEnd_o = degenerate || (ftw_i == start_i);
    end else if (ftw_i == stop_i) begin
      nextFtw_o = satSub(stop_i, step_i, start_i);
      down_o    = 1'b1;
    end
  end

  // start was the last point of the previous pass, so the new up leg skips it.
  assign restartFtw_o = satAdd(start_i, step_i, stop_i);
`else
  // Sawtooth: climb to stop, clamping so the last point is exactly stop.
  assign nextFtw_o    = satAdd(ftw_i, step_i, stop_i);
  assign passEnd_o    = degenerate || (ftw_i == stop_i);
  assign restartFtw_o = start_i;
`endif

endmodule

// File: rtl/ad9854_sweep_ctrl.sv
// ad9854_sweep_ctrl
// Upstream stage of the AD9854 register writer. Drives the FTW bus and the
// set request, running either a single set or a linear frequency sweep, and
// paces each point: setkey hold, settle for the write burst, then dwell.
// Optional feature: SWEEP_PINGPONG_EN makes each sweep pass go up and back down.
// Ports:
//   clk_i        clock, single domain
//   rst_i        synchronous active-high reset
//   go_i         start pulse, honoured only in IDLE
//   abort_i      stop at the next edge from any state, keeps freqw
//   mode_i       0 = sweep, 1 = single set of start
//   cont_i       sweep restarts after each pass
//   start_ftw_i  first FTW
//   stop_ftw_i   last FTW
//   step_ftw_i   FTW increment per point
//   dwell_i      hold cycles per point after settling, 0 = none
//   freqw_o      FTW to the writer
//   setkey_o     set request to the writer
//   busy_o       high outside IDLE
//   pass_done_o  one-cycle pulse at the end of each pass
//   point_idx_o  0-based point index within the pass, saturating
module ad9854_sweep_ctrl
  import ad9854_pkg::*;
#(
  parameter int SET_HOLD   = 16,
  parameter int SETTLE_CYC = 32,
  parameter int DWELL_W    = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               go_i,
  input  logic               abort_i,
  input  logic               mode_i,
  input  logic               cont_i,
  input  logic [FTW_W-1:0]   start_ftw_i,
  input  logic [FTW_W-1:0]   stop_ftw_i,
  input  logic [FTW_W-1:0]   step_ftw_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [FTW_W-1:0]   freqw_o,
  output logic               setkey_o,
  output logic               busy_o,
  output logic               pass_done_o,
  output logic [15:0]        point_idx_o
);

  // One counter serves all timed states, so it must hold the longest of them.
  localparam int CNT_W = (DWELL_W > 16) ? DWELL_W : 16;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SET_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  sweep_state_t        state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FTW_W-1:0]    freqw_q;
  logic                setkey_q;
  logic                busy_q;
  logic                passDone_q;
  logic [15:0]         pointIdx_q;
  logic [FTW_W-1:0]    start_q;
  logic [FTW_W-1:0]    stop_q;
  logic [FTW_W-1:0]    step_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic                mode_q;
  logic                cont_q;

  logic [FTW_W-1:0]    freqw_d;
  logic [FTW_W-1:0]    freqwRestart_d;
  logic                passEnd_d;
  logic [15:0]         pointIdx_d;
  logic [CNT_W-1:0]    dwellLast;

`ifdef SWEEP_PINGPONG_EN
  logic                down_q;
  logic                down_d;
`endif

  assign pointIdx_d = (pointIdx_q == 16'hFFFF) ? pointIdx_q : pointIdx_q + 16'd1;
  assign dwellLast  = CNT_W'(dwell_q - DWELL_W'(1));

  ad9854_sweep_step u_step (
    .ftw_i        (freqw_q),
    .start_i      (start_q),
    .stop_i       (stop_q),
    .step_i       (step_q),
    .single_i     (mode_q),
`ifdef SWEEP_PINGPONG_EN
    .down_i       (down_q),
    .down_o       (down_d),
`endif
    .nextFtw_o    (freqw_d),
    .restartFtw_o (freqwRestart_d),
    .passEnd_o    (passEnd_d)
  );

  // Main sequencer. pass_done is registered on the edge entering STEP so it
  // is high during the STEP cycle itself; the end-of-pass decision only
  // depends on latched settings and the stable freqw, so it is valid early.
  // Each STEP exit that starts a new point loads freqw and raises setkey on
  // the same edge, keeping the FTW stable for the whole point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      freqw_q    <= '0;
      setkey_q   <= 1'b0;
      busy_q     <= 1'b0;
      passDone_q <= 1'b0;
      pointIdx_q <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      mode_q     <= 1'b0;
      cont_q     <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      down_q     <= 1'b0;
`endif
    end else if (abort_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      setkey_q   <= 1'b0;
      busy_q     <= 1'b0;
      passDone_q <= 1'b0;
    end else begin
      passDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_i) begin
            start_q    <= start_ftw_i;
            stop_q     <= stop_ftw_i;
            step_q     <= step_ftw_i;
            dwell_q    <= dwell_i;
            mode_q     <= mode_i;
            cont_q     <= cont_i;
            freqw_q    <= start_ftw_i;
            pointIdx_q <= '0;
            setkey_q   <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= PULSE;
`ifdef SWEEP_PINGPONG_EN
            down_q     <= 1'b0;
`endif
          end
        end
        PULSE: begin
          if (cnt_q == HOLD_LAST) begin
            setkey_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= SETTLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q <= '0;
            if (dwell_q == '0) begin
              state_q    <= STEP;
              passDone_q <= passEnd_d;
            end else begin
              state_q <= DWELL;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DWELL: begin
          if (cnt_q == dwellLast) begin
            cnt_q      <= '0;
            state_q    <= STEP;
            passDone_q <= passEnd_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STEP: begin
          if (passEnd_d) begin
            if (cont_q && !mode_q) begin
              freqw_q    <= freqwRestart_d;
              pointIdx_q <= '0;
              setkey_q   <= 1'b1;
              state_q    <= PULSE;
`ifdef SWEEP_PINGPONG_EN
              down_q     <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            freqw_q    <= freqw_d;
            pointIdx_q <= pointIdx_d;
            setkey_q   <= 1'b1;
            state_q    <= PULSE;
`ifdef SWEEP_PINGPONG_EN
            down_q     <= down_d;
`endif
          end
        end
        default: begin
          state_q  <= IDLE;
          setkey_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // The hold must outlast the writer's debounce and the settle wait must
  // cover its write burst, otherwise points would be lost downstream.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (SET_HOLD > KEY_SR) else $error("SET_HOLD must exceed KEY_SR");
      assert (SETTLE_CYC >= WR_BURST) else $error("SETTLE_CYC must cover WR_BURST");
    end
  end

  assign freqw_o     = freqw_q;
  assign setkey_o    = setkey_q;
  assign busy_o      = busy_q;
  assign pass_done_o = passDone_q;
  assign point_idx_o = pointIdx_q;

endmodule

// File: tb/tb_ad9854_sweep_ctrl.sv
// tb_ad9854_sweep_ctrl
// Table-driven bench for ad9854_sweep_ctrl: each vector is run from go to
// the end of its pass and the observed points, timing and pass_done are
// compared with hand-computed values; abort, reset and continuous sweeps
// are exercised by short hand-written sequences.
// Honours SWEEP_PINGPONG_EN to select the matching expected point lists.
module tb_ad9854_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        go_i;
  logic        abort_i;
  logic        mode_i;
  logic        cont_i;
  logic [31:0] start_ftw_i;
  logic [31:0] stop_ftw_i;
  logic [31:0] step_ftw_i;
  logic [23:0] dwell_i;
  logic [31:0] freqw_o;
  logic        setkey_o;
  logic        busy_o;
  logic        pass_done_o;
  logic [15:0] point_idx_o;

  int checkCount = 0;
  int errCount   = 0;

  always #5 clk = ~clk;

  ad9854_sweep_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .go_i        (go_i),
    .abort_i     (abort_i),
    .mode_i      (mode_i),
    .cont_i      (cont_i),
    .start_ftw_i (start_ftw_i),
    .stop_ftw_i  (stop_ftw_i),
    .step_ftw_i  (step_ftw_i),
    .dwell_i     (dwell_i),
    .freqw_o     (freqw_o),
    .setkey_o    (setkey_o),
    .busy_o      (busy_o),
    .pass_done_o (pass_done_o),
    .point_idx_o (point_idx_o)
  );

  typedef struct packed {
    logic             mode;
    logic             cont;
    logic [31:0]      start;
    logic [31:0]      stop;
    logic [31:0]      step;
    logic [23:0]      dwell;
    logic [3:0]       nPts;
    logic [7:0][31:0] ftw;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  // What the monitor saw during the last run.
  int          obsRises;
  int          obsPdCount;
  int          obsPdCyc;
  int          obsEnd;
  int          obsStableErr;
  logic [31:0] obsFtw   [16];
  logic [15:0] obsIdx   [16];
  int          obsCyc   [16];
  int          obsWidth [16];

  function automatic logic [7:0][31:0] mkFtw(input logic [31:0] a0, input logic [31:0] a1,
                                              input logic [31:0] a2, input logic [31:0] a3,
                                              input logic [31:0] a4, input logic [31:0] a5,
                                              input logic [31:0] a6);
    logic [7:0][31:0] r;
    r    = '0;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6;
    return r;
  endfunction

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample once per cycle at the falling edge, recording setkey rises,
  // setkey widths, pass_done pulses and unexpected freqw changes. Stops when
  // busy drops, when maxRises rises were seen, or when the budget runs out.
  task automatic observe(input int maxRises, input bit pokeGo, input int budget);
    logic        prevKey;
    logic [31:0] prevFtw;
    int          hiLen;
    obsRises = 0; obsPdCount = 0; obsPdCyc = -1; obsEnd = -1; obsStableErr = 0;
    for (int i = 0; i < 16; i++) obsWidth[i] = 0;
    prevKey = 1'b0;
    prevFtw = freqw_o;
    hiLen   = 0;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      if (pokeGo) go_i = (c == 20);
      if (setkey_o && !prevKey) begin
        if (obsRises < 16) begin
          obsFtw[obsRises] = freqw_o;
          obsIdx[obsRises] = point_idx_o;
          obsCyc[obsRises] = c;
        end
        obsRises++;
        hiLen = 0;
      end else if (freqw_o !== prevFtw) begin
        obsStableErr++;
      end
      if (setkey_o) hiLen++;
      if (!setkey_o && prevKey && obsRises > 0 && obsRises <= 16) obsWidth[obsRises-1] = hiLen;
      if (pass_done_o) begin
        obsPdCount++;
        obsPdCyc = c;
      end
      prevKey = setkey_o;
      prevFtw = freqw_o;
      if (!busy_o) begin
        obsEnd = c;
        break;
      end
      if (maxRises > 0 && obsRises >= maxRises) break;
    end
  endtask

  // Drive a vector, pulse go, then scramble the live inputs so only the
  // latched copies can explain the observed points. Cycle 0 is the first
  // falling edge after the edge that sampled go.
  task automatic applyStimulus(input vec_t vv, input bit pokeGo, input int maxRises, input int budget);
    @(negedge clk);
    mode_i      = vv.mode;
    cont_i      = vv.cont;
    start_ftw_i = vv.start;
    stop_ftw_i  = vv.stop;
    step_ftw_i  = vv.step;
    dwell_i     = vv.dwell;
    go_i        = 1'b1;
    @(negedge clk);
    go_i        = 1'b0;
    mode_i      = ~vv.mode;
    cont_i      = ~vv.cont;
    start_ftw_i = ~vv.start;
    stop_ftw_i  = 32'h5;
    step_ftw_i  = vv.step + 32'd7;
    dwell_i     = vv.dwell + 24'd3;
    observe(maxRises, pokeGo, budget);
  endtask

  // Compare a completed run against its table entry. Points are one period
  // apart (STEP + hold + settle + dwell); the first has no STEP cycle, and
  // pass_done is high in the STEP cycle of the last point.
  task automatic checkRun(input int v);
    int period;
    int n;
    int pdExp;
    period = 49 + int'(vecs[v].dwell);
    n      = int'(vecs[v].nPts);
    pdExp  = (n - 1) * period + 48 + int'(vecs[v].dwell);
    checkOutput($sformatf("v%0d points", v), 32'(obsRises), 32'(n));
    for (int k = 0; k < n && k < obsRises; k++) begin
      checkOutput($sformatf("v%0d ftw%0d", v, k), obsFtw[k], vecs[v].ftw[k]);
      checkOutput($sformatf("v%0d idx%0d", v, k), 32'(obsIdx[k]), 32'(k));
      checkOutput($sformatf("v%0d rise%0d", v, k), 32'(obsCyc[k]), 32'(k * period));
      checkOutput($sformatf("v%0d width%0d", v, k), 32'(obsWidth[k]), 32'd16);
    end
    checkOutput($sformatf("v%0d passDoneCount", v), 32'(obsPdCount), 32'd1);
    checkOutput($sformatf("v%0d passDoneCycle", v), 32'(obsPdCyc), 32'(pdExp));
    checkOutput($sformatf("v%0d busyFall", v), 32'(obsEnd), 32'(pdExp + 1));
    checkOutput($sformatf("v%0d freqwStable", v), 32'(obsStableErr), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        cv;
    logic [31:0] expFtw [9];
    logic [15:0] expIdx [9];
    int          nObs;
    int          expPd;

    vecs[0] = '{1'b1, 1'b0, 32'h1000_0000, 32'h2000_0000, 32'd5, 24'd0, 4'd1,
                mkFtw(32'h1000_0000, 0, 0, 0, 0, 0, 0)};
`ifdef SWEEP_PINGPONG_EN
    vecs[1] = '{1'b0, 1'b0, 32'd100, 32'd400, 32'd100, 24'd5, 4'd7,
                mkFtw(32'd100, 32'd200, 32'd300, 32'd400, 32'd300, 32'd200, 32'd100)};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd0, 4'd5,
                mkFtw(32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF, 32'hFFFF_FF7F, 32'hFFFF_FF00, 0, 0)};
    vecs[6] = '{1'b0, 1'b0, 32'd0, 32'd250, 32'd100, 24'd1, 4'd7,
                mkFtw(32'd0, 32'd100, 32'd200, 32'd250, 32'd150, 32'd50, 32'd0)};
`else
    vecs[1] = '{1'b0, 1'b0, 32'd100, 32'd400, 32'd100, 24'd5, 4'd4,
                mkFtw(32'd100, 32'd200, 32'd300, 32'd400, 0, 0, 0)};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd0, 4'd3,
                mkFtw(32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF, 0, 0, 0, 0)};
    vecs[6] = '{1'b0, 1'b0, 32'd0, 32'd250, 32'd100, 24'd1, 4'd4,
                mkFtw(32'd0, 32'd100, 32'd200, 32'd250, 0, 0, 0)};
`endif
    vecs[3] = '{1'b0, 1'b0, 32'd500, 32'd900, 32'd0, 24'd2, 4'd1,
                mkFtw(32'd500, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{1'b0, 1'b0, 32'd900, 32'd500, 32'd10, 24'd0, 4'd1,
                mkFtw(32'd900, 0, 0, 0, 0, 0, 0)};
    vecs[5] = '{1'b0, 1'b0, 32'h1234, 32'h1234, 32'd1, 24'd0, 4'd1,
                mkFtw(32'h1234, 0, 0, 0, 0, 0, 0)};

    rst_i = 1'b1; go_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; cont_i = 1'b0;
    start_ftw_i = '0; stop_ftw_i = '0; step_ftw_i = '0; dwell_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    checkOutput("reset freqw", freqw_o, 32'd0);
    checkOutput("reset setkey", 32'(setkey_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset passDone", 32'(pass_done_o), 32'd0);
    checkOutput("reset pointIdx", 32'(point_idx_o), 32'd0);

    // Table vectors, with a stray go in the middle of every run.
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v], 1'b1, 0, 1000);
      checkRun(v);
    end

    // Abort in the middle of the second point's setkey pulse.
    applyStimulus(vecs[1], 1'b0, 2, 200);
    checkOutput("abort reached point 2", 32'(obsRises), 32'd2);
    repeat (5) @(negedge clk);
    checkOutput("abort pre setkey", 32'(setkey_o), 32'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abort setkey", 32'(setkey_o), 32'd0);
    checkOutput("abort busy", 32'(busy_o), 32'd0);
    checkOutput("abort passDone", 32'(pass_done_o), 32'd0);
    checkOutput("abort freqw held", freqw_o, 32'd200);
    checkOutput("abort pointIdx held", 32'(point_idx_o), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("abort stays idle", 32'(busy_o), 32'd0);

    // A fresh go after abort starts again at start.
    applyStimulus(vecs[1], 1'b0, 1, 50);
    checkOutput("restart ftw", obsFtw[0], 32'd100);
    checkOutput("restart idx", 32'(obsIdx[0]), 32'd0);
    checkOutput("restart rise", 32'(obsCyc[0]), 32'd0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abort in pulse busy", 32'(busy_o), 32'd0);

    // abort and go together in IDLE: abort wins.
    abort_i = 1'b1;
    go_i    = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    go_i    = 1'b0;
    checkOutput("abort+go busy", 32'(busy_o), 32'd0);
    checkOutput("abort+go setkey", 32'(setkey_o), 32'd0);

    // Continuous sweep: points are one full period apart across the wrap.
`ifdef SWEEP_PINGPONG_EN
    cv = '{1'b0, 1'b1, 32'd0, 32'd300, 32'd100, 24'd0, 4'd0, '0};
    nObs = 9;
    expFtw = '{32'd0, 32'd100, 32'd200, 32'd300, 32'd200, 32'd100, 32'd0, 32'd100, 32'd200};
    expIdx = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd1};
    expPd  = 1;
`else
    cv = '{1'b0, 1'b1, 32'd0, 32'd100, 32'd100, 24'd0, 4'd0, '0};
    nObs = 5;
    expFtw = '{32'd0, 32'd100, 32'd0, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    expIdx = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    expPd  = 2;
`endif
    applyStimulus(cv, 1'b0, nObs, 1000);
    checkOutput("cont points", 32'(obsRises), 32'(nObs));
    for (int k = 0; k < nObs && k < obsRises; k++) begin
      checkOutput($sformatf("cont ftw%0d", k), obsFtw[k], expFtw[k]);
      checkOutput($sformatf("cont idx%0d", k), 32'(obsIdx[k]), 32'(expIdx[k]));
      checkOutput($sformatf("cont rise%0d", k), 32'(obsCyc[k]), 32'(k * 49));
    end
    checkOutput("cont passDoneCount", 32'(obsPdCount), 32'(expPd));
    checkOutput("cont still busy", 32'(busy_o), 32'd1);

    // Reset mid-run clears freqw and the point index as well as the FSM.
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checkOutput("rst run freqw", freqw_o, 32'd0);
    checkOutput("rst run pointIdx", 32'(point_idx_o), 32'd0);
    checkOutput("rst run busy", 32'(busy_o), 32'd0);
    checkOutput("rst run setkey", 32'(setkey_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
